// File: rtl/router_sync.sv
// N_IN x N_OUT channel router with double-buffered routing config and registered outputs.
// Config writes land in shadow registers; update_in commits all outputs at once.
module router_sync #(
    parameter int W_CHAN = 16,
    parameter int W_SEL  = 4,
    parameter int N_IN   = 8,
    parameter int N_OUT  = 8
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [W_CHAN*N_IN-1:0]    data_bus_in,
    input  logic [N_IN-1:0]           data_valid_in,
    input  logic                      cfg_wr_in,
    input  logic [W_SEL-1:0]          cfg_dest_in,
    input  logic [W_SEL-1:0]          cfg_src_in,
    input  logic                      cfg_active_in,
    input  logic                      cfg_hold_in,
    input  logic                      update_in,
    output logic [W_CHAN*N_OUT-1:0]   data_bus_out,
    output logic [N_OUT-1:0]          data_valid_out,
    output logic                      cfg_err_out
);

    logic [W_SEL-1:0]  sh_src_q [N_OUT];
    logic [N_OUT-1:0]  sh_act_q;
    logic [N_OUT-1:0]  sh_hold_q;
    logic [W_SEL-1:0]  lv_src_q [N_OUT];
    logic [N_OUT-1:0]  lv_act_q;
    logic [N_OUT-1:0]  lv_hold_q;
    logic [W_CHAN-1:0] dout_q [N_OUT];
    logic [W_CHAN-1:0] dout_d [N_OUT];
    logic [W_CHAN-1:0] sel_data [N_OUT];
    logic [N_OUT-1:0]  sel_vld;
    logic [N_OUT-1:0]  vld_q;
    logic [N_OUT-1:0]  vld_d;
    logic              err_q;
    logic              wr_ok;

    // One extra bit so N_OUT / N_IN themselves are representable in the compare.
    assign wr_ok = ({1'b0, cfg_dest_in} < (W_SEL+1)'(N_OUT)) &&
                   ({1'b0, cfg_src_in}  < (W_SEL+1)'(N_IN));

    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            sel_data[j] = '0;
            sel_vld[j]  = 1'b0;
            for (int k = 0; k < N_IN; k++) begin
                if (lv_src_q[j] == W_SEL'(k)) begin
                    sel_data[j] = data_bus_in[k*W_CHAN +: W_CHAN];
                    sel_vld[j]  = data_valid_in[k];
                end
            end
            dout_d[j] = dout_q[j];
            vld_d[j]  = 1'b0;
            if (lv_act_q[j]) begin
                vld_d[j] = sel_vld[j];
                if (sel_vld[j]) begin
                    dout_d[j] = sel_data[j];
                end
            end else if (!lv_hold_q[j]) begin
                dout_d[j] = '0;
            end
        end
    end

    // Commit reads the shadow before this cycle's write lands (non-blocking semantics).
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int j = 0; j < N_OUT; j++) begin
                sh_src_q[j] <= '0;
                lv_src_q[j] <= '0;
                dout_q[j]   <= '0;
            end
            sh_act_q  <= '0;
            sh_hold_q <= '0;
            lv_act_q  <= '0;
            lv_hold_q <= '0;
            vld_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            for (int j = 0; j < N_OUT; j++) begin
                dout_q[j] <= dout_d[j];
                if (update_in) begin
                    lv_src_q[j]  <= sh_src_q[j];
                    lv_act_q[j]  <= sh_act_q[j];
                    lv_hold_q[j] <= sh_hold_q[j];
                end
                if (cfg_wr_in && wr_ok && cfg_dest_in == W_SEL'(j)) begin
                    sh_src_q[j]  <= cfg_src_in;
                    sh_act_q[j]  <= cfg_active_in;
                    sh_hold_q[j] <= cfg_hold_in;
                end
            end
            vld_q <= vld_d;
            if (cfg_wr_in && !wr_ok) begin
                err_q <= 1'b1;
            end
        end
    end

    for (genvar j = 0; j < N_OUT; j++) begin : g_pack
        assign data_bus_out[j*W_CHAN +: W_CHAN] = dout_q[j];
    end

    assign data_valid_out = vld_q;
    assign cfg_err_out    = err_q;

endmodule

// File: tb/tb_router_sync.sv
// Bench for router_sync: an 8x8 and a 6x8 instance share stimulus; a spec-level model
// predicts both every cycle, and directed literals pin the key scenarios.
module tb_router_sync;

    logic         clk = 1'b0;
    logic         rst_in;
    logic [127:0] bus_in;
    logic [7:0]   vin;
    logic         cfg_wr, cfg_act, cfg_hold, upd;
    logic [3:0]   cfg_dest, cfg_src;
    logic [127:0] dout8, dout6;
    logic [7:0]   vout8, vout6;
    logic         err8, err6;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    router_sync #(.W_CHAN(16), .W_SEL(4), .N_IN(8), .N_OUT(8)) u8 (
        .clk_in(clk), .rst_in(rst_in), .data_bus_in(bus_in), .data_valid_in(vin),
        .cfg_wr_in(cfg_wr), .cfg_dest_in(cfg_dest), .cfg_src_in(cfg_src),
        .cfg_active_in(cfg_act), .cfg_hold_in(cfg_hold), .update_in(upd),
        .data_bus_out(dout8), .data_valid_out(vout8), .cfg_err_out(err8));

    router_sync #(.W_CHAN(16), .W_SEL(4), .N_IN(6), .N_OUT(8)) u6 (
        .clk_in(clk), .rst_in(rst_in), .data_bus_in(bus_in[95:0]), .data_valid_in(vin[5:0]),
        .cfg_wr_in(cfg_wr), .cfg_dest_in(cfg_dest), .cfg_src_in(cfg_src),
        .cfg_active_in(cfg_act), .cfg_hold_in(cfg_hold), .update_in(upd),
        .data_bus_out(dout6), .data_valid_out(vout6), .cfg_err_out(err6));

    // Model state, index 0 = 8-input instance, 1 = 6-input instance.
    typedef struct packed { logic [3:0] src; logic act; logic hold; } cfg_t;
    cfg_t        m_sh  [2][8];
    cfg_t        m_lv  [2][8];
    logic [15:0] m_out [2][8];
    logic [7:0]  m_vld [2];
    logic        m_err [2];
    bit          started = 0;
    int          nin;
    int          s;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            nin = (i == 0) ? 8 : 6;
            if (rst_in) begin
                for (int j = 0; j < 8; j++) begin
                    m_sh[i][j]  = '0;
                    m_lv[i][j]  = '0;
                    m_out[i][j] = '0;
                end
                m_vld[i] = '0;
                m_err[i] = 1'b0;
            end else begin
                for (int j = 0; j < 8; j++) begin
                    s = int'(m_lv[i][j].src);
                    m_vld[i][j] = 1'b0;
                    if (m_lv[i][j].act) begin
                        if (s < nin && vin[s]) begin
                            m_out[i][j] = bus_in[s*16 +: 16];
                            m_vld[i][j] = 1'b1;
                        end
                    end else if (!m_lv[i][j].hold) begin
                        m_out[i][j] = '0;
                    end
                end
                if (upd) begin
                    for (int j = 0; j < 8; j++) m_lv[i][j] = m_sh[i][j];
                end
                if (cfg_wr) begin
                    if (int'(cfg_dest) < 8 && int'(cfg_src) < nin)
                        m_sh[i][cfg_dest[2:0]] = '{cfg_src, cfg_act, cfg_hold};
                    else
                        m_err[i] = 1'b1;
                end
            end
        end
        if (rst_in) started = 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_exp(input int i);
        logic [127:0] r;
        for (int j = 0; j < 8; j++) r[j*16 +: 16] = m_out[i][j];
        return r;
    endfunction

    always @(negedge clk) begin
        if (started) begin
            chk("model bus8",  dout8, pack_exp(0));
            chk("model vld8",  vout8, m_vld[0]);
            chk("model err8",  err8,  m_err[0]);
            chk("model bus6",  dout6, pack_exp(1));
            chk("model vld6",  vout6, m_vld[1]);
            chk("model err6",  err6,  m_err[1]);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg(input int d, input int sr, input bit a, input bit h, input bit with_upd);
        cfg_wr = 1; cfg_dest = 4'(d); cfg_src = 4'(sr); cfg_act = a; cfg_hold = h; upd = with_upd;
        tick();
        cfg_wr = 0; upd = 0;
    endtask

    task automatic commit();
        upd = 1;
        tick();
        upd = 0;
    endtask

    task automatic set_in(input int k, input logic [15:0] v);
        bus_in[k*16 +: 16] = v;
        vin[k] = 1'b1;
    endtask

    task automatic send();
        tick();
        vin = '0;
    endtask

    function automatic logic [15:0] o8(input int j);
        return dout8[j*16 +: 16];
    endfunction

    function automatic logic [15:0] o6(input int j);
        return dout6[j*16 +: 16];
    endfunction

    initial begin
        rst_in = 0; bus_in = '0; vin = '0; cfg_wr = 0; cfg_dest = '0; cfg_src = '0;
        cfg_act = 0; cfg_hold = 0; upd = 0;
        @(negedge clk);

        // T1: reset wins over live traffic and config activity
        rst_in = 1; bus_in = {8{16'hA5C3}}; vin = 8'hFF;
        cfg_wr = 1; cfg_dest = 4'd1; cfg_src = 4'd9; cfg_act = 1; upd = 1;
        tick(); tick();
        rst_in = 0; cfg_wr = 0; upd = 0;
        tick();
        chk("T1 bus8", dout8, 128'h0);
        chk("T1 vld8", vout8, 8'h00);
        chk("T1 err6", err6, 1'b0);
        vin = '0;

        // T2: out3 <- in5, one-cycle latency
        cfg(3, 5, 1, 0, 0);
        commit();
        set_in(5, 16'h1234);
        chk("T2 pre-vld", vout8, 8'h00);
        send();
        chk("T2 out3", o8(3), 16'h1234);
        chk("T2 vld", vout8, 8'h08);
        chk("T2 others", dout8 & ~(128'hFFFF << 48), 128'h0);
        tick();
        chk("T2 hold", o8(3), 16'h1234);
        chk("T2 vld-drop", vout8, 8'h00);

        // T3: swap routing only after commit
        cfg(0, 0, 1, 0, 0); cfg(1, 1, 1, 0, 0); commit();
        set_in(0, 16'hAAAA); set_in(1, 16'h5555); send();
        chk("T3 out0 init", o8(0), 16'hAAAA);
        cfg(0, 1, 1, 0, 0); cfg(1, 0, 1, 0, 0);
        set_in(0, 16'h1111); set_in(1, 16'h2222); send();
        chk("T3 out0 no-commit", o8(0), 16'h1111);
        chk("T3 out1 no-commit", o8(1), 16'h2222);
        commit();
        set_in(0, 16'h3333); set_in(1, 16'h4444); send();
        chk("T3 out0 swapped", o8(0), 16'h4444);
        chk("T3 out1 swapped", o8(1), 16'h3333);

        // T4: write concurrent with commit takes effect only at the next commit
        cfg(2, 0, 1, 0, 0); commit();
        cfg(2, 7, 1, 0, 1);
        set_in(0, 16'h0A0A); set_in(7, 16'h0707); send();
        chk("T4 out2 old", o8(2), 16'h0A0A);
        chk("T4 err6 src7", err6, 1'b1);
        chk("T4 err8 src7", err8, 1'b0);
        commit();
        set_in(0, 16'h0B0B); set_in(7, 16'h0808); send();
        chk("T4 out2 new", o8(2), 16'h0808);
        chk("T4 u6 out2 kept", o6(2), 16'h0B0B);

        // T5: inactive hold then inactive zero
        cfg(4, 3, 1, 0, 0); commit();
        set_in(3, 16'hBEEF); send();
        chk("T5 out4", o8(4), 16'hBEEF);
        cfg(4, 3, 0, 1, 0); commit();
        set_in(3, 16'h1111); send();
        chk("T5 hold val", o8(4), 16'hBEEF);
        chk("T5 hold vld", vout8[4], 1'b0);
        cfg(4, 3, 0, 0, 0); commit();
        chk("T5 pre-zero", o8(4), 16'hBEEF);
        tick();
        chk("T5 zero", o8(4), 16'h0000);

        // Unstructured traffic over the current routing
        for (int c = 0; c < 24; c++) begin
            bus_in = {$urandom, $urandom, $urandom, $urandom};
            vin = 8'($urandom);
            tick();
        end
        vin = '0;

        // T6: bad source on the 6-input instance, then fan-out of in2
        rst_in = 1; tick(); rst_in = 0;
        chk("T6 err6 after rst", err6, 1'b0);
        cfg(0, 7, 1, 0, 0);
        chk("T6 err6 set", err6, 1'b1);
        chk("T6 err8 clear", err8, 1'b0);
        commit();
        set_in(7, 16'h7777); send();
        chk("T6 u6 out0 inactive", o6(0), 16'h0000);
        chk("T6 u8 out0 in7", o8(0), 16'h7777);
        for (int j = 0; j < 8; j++) cfg(j, 2, 1, 0, 0);
        commit();
        set_in(2, 16'hC0DE); send();
        chk("T6 fan bus8", dout8, {8{16'hC0DE}});
        chk("T6 fan vld8", vout8, 8'hFF);
        chk("T6 fan bus6", dout6, {8{16'hC0DE}});
        chk("T6 fan vld6", vout6, 8'hFF);
        cfg(8, 0, 1, 0, 0);
        chk("T6 dest8 err8", err8, 1'b1);
        tick();
        chk("T6 err6 sticky", err6, 1'b1);
        rst_in = 1; tick(); rst_in = 0;
        chk("T6 err6 rst clear", err6, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
